// File: rtl/alu_seq.sv
// Multi-cycle sequencer in front of the 8-bit hmc-6502 ALU: drives operands, derives NZCV, registers results.
// Optional decimal ADC/SBC correction is enabled by defining ALU_SEQ_BCD_EN.
module alu_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] op_sel,
    input  logic [7:0] operand_a,
    input  logic [7:0] operand_b,
    input  logic       c_flag,
    input  logic       d_flag,
    input  logic [7:0] alu_y,
    input  logic       alu_cout,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    output logic       alu_cin,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       result_we,
    output logic       n,
    output logic       z,
    output logic       c,
    output logic       v,
    output logic [3:0] flag_we
);

    localparam logic [3:0] OP_ADC = 4'h0;
    localparam logic [3:0] OP_SBC = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_ORA = 4'h3;
    localparam logic [3:0] OP_EOR = 4'h4;
    localparam logic [3:0] OP_ASL = 4'h5;
    localparam logic [3:0] OP_LSR = 4'h6;
    localparam logic [3:0] OP_ROL = 4'h7;
    localparam logic [3:0] OP_ROR = 4'h8;
    localparam logic [3:0] OP_INC = 4'h9;
    localparam logic [3:0] OP_DEC = 4'hA;
    localparam logic [3:0] OP_CMP = 4'hB;
    localparam logic [3:0] OP_BIT = 4'hC;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_EOR = 4'd4;
    localparam logic [3:0] ALU_INC = 4'd5;
    localparam logic [3:0] ALU_DEC = 4'd6;
    localparam logic [3:0] ALU_ASL = 4'd7;
    localparam logic [3:0] ALU_ROL = 4'd8;
    localparam logic [3:0] ALU_ROR = 4'd9;

    typedef enum logic [2:0] {IDLE, EXEC, ADJ_LO, ADJ_HI, DONE} state_t;

    state_t     state;
    logic [3:0] op_r;

    logic [7:0] drv_a;
    logic [7:0] drv_b;
    logic [3:0] drv_op;
    logic       drv_cin;
    logic [3:0] exec_we;
    logic       exec_rwe;
    logic       v_add;
    logic       exec_n;
    logic       exec_v;

    // ALU drive for the operation being accepted this cycle
    always_comb begin
        drv_a   = operand_a;
        drv_b   = 8'h00;
        drv_op  = ALU_ADD;
        drv_cin = 1'b0;
        case (op_sel)
            OP_ADC: begin drv_b = operand_b;  drv_cin = c_flag; end
            OP_SBC: begin drv_b = ~operand_b; drv_cin = c_flag; end
            OP_CMP: begin drv_b = ~operand_b; drv_cin = 1'b1;   end
            OP_AND: begin drv_b = operand_b;  drv_op = ALU_AND; end
            OP_ORA: begin drv_b = operand_b;  drv_op = ALU_OR;  end
            OP_EOR: begin drv_b = operand_b;  drv_op = ALU_EOR; end
            OP_BIT: begin drv_b = operand_b;  drv_op = ALU_AND; end
            OP_ASL: drv_op = ALU_ASL;
            OP_LSR: drv_op = ALU_ROR;
            OP_ROL: begin drv_op = ALU_ROL; drv_cin = c_flag; end
            OP_ROR: begin drv_op = ALU_ROR; drv_cin = c_flag; end
            OP_INC: begin drv_op = ALU_INC; drv_cin = 1'b1;   end
            OP_DEC: begin drv_op = ALU_DEC; drv_cin = 1'b1;   end
            default: drv_a = 8'h00;
        endcase
    end

    // Flags and write enables at the end of the binary pass
    always_comb begin
        exec_we  = 4'b0000;
        exec_rwe = 1'b0;
        v_add    = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
        exec_n   = (op_r == OP_BIT) ? alu_b[7] : alu_y[7];
        exec_v   = (op_r == OP_BIT) ? alu_b[6] : v_add;
        case (op_r)
            OP_ADC, OP_SBC: begin exec_we = 4'b1111; exec_rwe = 1'b1; end
            OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC: begin exec_we = 4'b1100; exec_rwe = 1'b1; end
            OP_ASL, OP_LSR, OP_ROL, OP_ROR: begin exec_we = 4'b1110; exec_rwe = 1'b1; end
            OP_CMP: exec_we = 4'b1110;
            OP_BIT: exec_we = 4'b1101;
            default: ;
        endcase
    end

`ifdef ALU_SEQ_BCD_EN
    logic       d_r;
    logic       c_bin;
    logic       v_bin;
    logic       c_dec;
    logic       is_dec;
    logic       half;
    logic [7:0] lo_add;
    logic [7:0] hi_add;
    logic       hi_c;

    // Decimal correction constants; lo uses the binary pass, hi the lo-adjusted value
    always_comb begin
        is_dec = d_r && ((op_r == OP_ADC) || (op_r == OP_SBC));
        half   = (5'(alu_a[3:0]) + 5'(alu_b[3:0]) + 5'(alu_cin)) > 5'd15;
        hi_c   = c_bin;
        if (op_r == OP_ADC) begin
            lo_add = (half || (alu_y[3:0] > 4'd9)) ? 8'h06 : 8'h00;
            hi_c   = c_bin || alu_cout || (alu_y[7:4] > 4'd9);
            hi_add = hi_c ? 8'h60 : 8'h00;
        end else begin
            lo_add = half ? 8'h00 : 8'hFA;
            hi_add = c_bin ? 8'h00 : 8'hA0;
        end
    end
`else
    logic unused_d;
    assign unused_d = d_flag;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_r      <= 4'h0;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            alu_op    <= 4'h0;
            alu_cin   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 8'h00;
            result_we <= 1'b0;
            n         <= 1'b0;
            z         <= 1'b0;
            c         <= 1'b0;
            v         <= 1'b0;
            flag_we   <= 4'b0000;
`ifdef ALU_SEQ_BCD_EN
            d_r       <= 1'b0;
            c_bin     <= 1'b0;
            v_bin     <= 1'b0;
            c_dec     <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            result_we <= 1'b0;
            flag_we   <= 4'b0000;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= EXEC;
                        busy    <= 1'b1;
                        op_r    <= op_sel;
                        alu_a   <= drv_a;
                        alu_b   <= drv_b;
                        alu_op  <= drv_op;
                        alu_cin <= drv_cin;
`ifdef ALU_SEQ_BCD_EN
                        d_r     <= d_flag;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
`ifdef ALU_SEQ_BCD_EN
                    if (is_dec) begin
                        state   <= ADJ_LO;
                        c_bin   <= alu_cout;
                        v_bin   <= v_add;
                        alu_a   <= alu_y;
                        alu_b   <= lo_add;
                        alu_op  <= ALU_ADD;
                        alu_cin <= 1'b0;
                    end else
`endif
                    begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= alu_y;
                        result_we <= exec_rwe;
                        n         <= exec_n;
                        z         <= (alu_y == 8'h00);
                        c         <= alu_cout;
                        v         <= exec_v;
                        flag_we   <= exec_we;
                        alu_a     <= 8'h00;
                        alu_b     <= 8'h00;
                        alu_op    <= 4'h0;
                        alu_cin   <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_BCD_EN
                ADJ_LO: begin
                    state <= ADJ_HI;
                    c_dec <= hi_c;
                    alu_a <= alu_y;
                    alu_b <= hi_add;
                end
                ADJ_HI: begin
                    state     <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    result    <= alu_y;
                    result_we <= 1'b1;
                    n         <= alu_y[7];
                    z         <= (alu_y == 8'h00);
                    c         <= c_dec;
                    v         <= v_bin;
                    flag_we   <= 4'b1111;
                    alu_a     <= 8'h00;
                    alu_b     <= 8'h00;
                    alu_op    <= 4'h0;
                    alu_cin   <= 1'b0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a behavioural 8-bit ALU model.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] op_sel;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       c_flag;
    logic       d_flag;
    logic [7:0] alu_y;
    logic       alu_cout;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic       alu_cin;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       result_we;
    logic       n, z, c, v;
    logic [3:0] flag_we;

    int checks = 0;
    int errors = 0;

`ifdef ALU_SEQ_BCD_EN
    localparam int DLAT = 4;
`else
    localparam int DLAT = 2;
`endif

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .reset(reset), .start(start), .op_sel(op_sel),
        .operand_a(operand_a), .operand_b(operand_b), .c_flag(c_flag), .d_flag(d_flag),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_cin(alu_cin), .busy(busy), .done(done),
        .result(result), .result_we(result_we), .n(n), .z(z), .c(c), .v(v),
        .flag_we(flag_we)
    );

    // Behavioural ALU responding to the sequencer's drive
    always_comb begin
        alu_y    = 8'h00;
        alu_cout = 1'b0;
        case (alu_op)
            4'd0: {alu_cout, alu_y} = 9'(alu_a) + 9'(alu_b) + 9'(alu_cin);
            4'd2: alu_y = alu_a | alu_b;
            4'd3: alu_y = alu_a & alu_b;
            4'd4: alu_y = alu_a ^ alu_b;
            4'd5: alu_y = alu_a + 8'd1;
            4'd6: alu_y = alu_a - 8'd1;
            4'd7: {alu_cout, alu_y} = {alu_a, 1'b0};
            4'd8: begin alu_cout = alu_a[7]; alu_y = {alu_a[6:0], alu_cin}; end
            4'd9: begin alu_cout = alu_a[0]; alu_y = {alu_cin, alu_a[7:1]}; end
            default: ;
        endcase
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       di;
        logic [7:0] res;
        logic [3:0] nzcv;
        logic [3:0] fwe;
        logic       rwe;
        int         lat;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic ci, input logic di, input logic [7:0] res,
                                input logic [3:0] nzcv, input logic [3:0] fwe, input logic rwe,
                                input int lat, input string name);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.ci = ci; t.di = di; t.res = res;
        t.nzcv = nzcv; t.fwe = fwe; t.rwe = rwe; t.lat = lat; t.name = name;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t);
        int cyc;
        @(negedge clk);
        op_sel = t.op; operand_a = t.a; operand_b = t.b; c_flag = t.ci; d_flag = t.di;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({t.name, " busy"}, 32'(busy), 32'd1);
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({t.name, " done"}, 32'(done), 32'd1);
        chk({t.name, " latency"}, 32'(cyc), 32'(t.lat));
        chk({t.name, " busy_at_done"}, 32'(busy), 32'd0);
        chk({t.name, " flag_we"}, 32'(flag_we), 32'(t.fwe));
        chk({t.name, " result_we"}, 32'(result_we), 32'(t.rwe));
        chk({t.name, " nzcv"}, 32'({n, z, c, v} & t.fwe), 32'(t.nzcv & t.fwe));
        if (t.rwe) chk({t.name, " result"}, 32'(result), 32'(t.res));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " outs"}, 32'({busy, done, result_we, n, z, c, v, alu_cin, flag_we, alu_op}), 32'd0);
        chk({name, " result"}, 32'(result), 32'd0);
        chk({name, " alu_ab"}, 32'({alu_a, alu_b}), 32'd0);
    endtask

    initial begin
        int dones;
        reset = 1'b1; start = 1'b0; op_sel = 4'h0; operand_a = 8'h00; operand_b = 8'h00;
        c_flag = 1'b0; d_flag = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        vecs.push_back(mk(4'h0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 4'b1001, 4'b1111, 1'b1, 2, "adc_ovf"));
`ifdef ALU_SEQ_BCD_EN
        vecs.push_back(mk(4'h0, 8'h58, 8'h46, 1'b0, 1'b1, 8'h04, 4'b0011, 4'b1111, 1'b1, DLAT, "adc_bcd"));
        vecs.push_back(mk(4'h1, 8'h15, 8'h06, 1'b1, 1'b1, 8'h09, 4'b0010, 4'b1111, 1'b1, DLAT, "sbc_bcd"));
        vecs.push_back(mk(4'h0, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 4'b0110, 4'b1111, 1'b1, DLAT, "adc_bcd_wrap"));
`else
        vecs.push_back(mk(4'h0, 8'h58, 8'h46, 1'b0, 1'b1, 8'h9E, 4'b1001, 4'b1111, 1'b1, DLAT, "adc_bcd"));
        vecs.push_back(mk(4'h1, 8'h15, 8'h06, 1'b1, 1'b1, 8'h0F, 4'b0010, 4'b1111, 1'b1, DLAT, "sbc_bcd"));
        vecs.push_back(mk(4'h0, 8'h99, 8'h01, 1'b0, 1'b1, 8'h9A, 4'b1000, 4'b1111, 1'b1, DLAT, "adc_bcd_wrap"));
`endif
        vecs.push_back(mk(4'h1, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 4'b1000, 4'b1111, 1'b1, 2, "sbc_borrow"));
        vecs.push_back(mk(4'h0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b0110, 4'b1111, 1'b1, 2, "adc_carry"));
        vecs.push_back(mk(4'hB, 8'h40, 8'h40, 1'b0, 1'b0, 8'h00, 4'b0110, 4'b1110, 1'b0, 2, "cmp_eq"));
        vecs.push_back(mk(4'hC, 8'h0F, 8'hC0, 1'b0, 1'b0, 8'h00, 4'b1101, 4'b1101, 1'b0, 2, "bit"));
        vecs.push_back(mk(4'h6, 8'h01, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0110, 4'b1110, 1'b1, 2, "lsr"));
        vecs.push_back(mk(4'h2, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 4'b0000, 4'b1100, 1'b1, 2, "and"));
        vecs.push_back(mk(4'h3, 8'h80, 8'h01, 1'b0, 1'b0, 8'h81, 4'b1000, 4'b1100, 1'b1, 2, "ora"));
        vecs.push_back(mk(4'h4, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 4'b0100, 4'b1100, 1'b1, 2, "eor"));
        vecs.push_back(mk(4'h5, 8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 4'b0010, 4'b1110, 1'b1, 2, "asl"));
        vecs.push_back(mk(4'h7, 8'h80, 8'h00, 1'b1, 1'b0, 8'h01, 4'b0010, 4'b1110, 1'b1, 2, "rol"));
        vecs.push_back(mk(4'h8, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 4'b1010, 4'b1110, 1'b1, 2, "ror"));
        vecs.push_back(mk(4'h9, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0100, 4'b1100, 1'b1, 2, "inc"));
        vecs.push_back(mk(4'hA, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 4'b1000, 4'b1100, 1'b1, 2, "dec"));
        vecs.push_back(mk(4'hE, 8'h12, 8'h34, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 2, "illegal"));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during EXEC of a decimal ADC aborts with no done
        @(negedge clk);
        op_sel = 4'h0; operand_a = 8'h58; operand_b = 8'h46; c_flag = 1'b0; d_flag = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        chk_all_zero("abort_next");
        reset = 1'b0;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || result_we || flag_we != 4'b0000) dones++;
        end
        chk("abort no_done", 32'(dones), 32'd0);
        chk("abort idle", 32'(busy), 32'd0);

        // start pulsed while busy is ignored
        @(negedge clk);
        op_sel = 4'h0; operand_a = 8'h01; operand_b = 8'h02; c_flag = 1'b0; d_flag = 1'b0;
        start = 1'b1;
        @(negedge clk);
        op_sel = 4'h9; operand_a = 8'h10;
        @(negedge clk);
        start = 1'b0;
        chk("ignore done", 32'(done), 32'd1);
        chk("ignore result", 32'(result), 32'h03);
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("ignore extra_done", 32'(dones), 32'd0);

        // start held through done gives back-to-back ops
        @(negedge clk);
        op_sel = 4'h2; operand_a = 8'h3C; operand_b = 8'hF0; c_flag = 1'b0; d_flag = 1'b0;
        start = 1'b1;
        @(negedge clk);
        op_sel = 4'h4; operand_a = 8'h0F; operand_b = 8'hF0;
        @(negedge clk);
        chk("b2b first_done", 32'(done), 32'd1);
        chk("b2b first_result", 32'(result), 32'h30);
        @(negedge clk);
        start = 1'b0;
        chk("b2b gap", 32'(done), 32'd0);
        chk("b2b busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b second_done", 32'(done), 32'd1);
        chk("b2b second_result", 32'(result), 32'hFF);
        chk("b2b second_flags", 32'({n, z, flag_we}), 32'({1'b1, 1'b0, 4'b1100}));
        @(negedge clk);
        chk("b2b hold_result", 32'({done, result}), 32'h0FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
